// File: rtl/mem_arbiter.sv
// Shares one 128-bit line memory between the I-cache and D-cache memory-side ports.
// Latency: a request sampled at edge N drives mem_read/mem_write in cycle N+1; ready is forwarded combinationally.
// Backpressure: requesters hold requests until their ready pulse; D has priority, bounded by an anti-starvation count.
//
// Ports:
//   clk, proc_reset            clock and asynchronous active-high reset
//   i_mem_* / d_mem_*          cache-side request (read/write/addr/wdata) and response (rdata/ready)
//   mem_*                      registered memory request, memory response (mem_rdata/mem_ready)
//   grant_d                    debug: 1 while the current/last owner is the D side
module mem_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant_d
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt;
    logic       i_req, d_req;
    logic       take_i, take_d;

    assign i_req = i_mem_read | i_mem_write;
    assign d_req = d_mem_read | d_mem_write;

    // D wins ties unless I has already been passed over LIMIT times.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_req && (!i_req || starve_cnt != LIMIT))
                    state_nxt = GNT_D;
                else if (i_req)
                    state_nxt = GNT_I;
            end
            GNT_I, GNT_D: begin
                if (mem_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign take_d = (state == IDLE) && (state_nxt == GNT_D);
    assign take_i = (state == IDLE) && (state_nxt == GNT_I);

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Memory request is captured once at grant and held until completion,
    // so the requester's inputs are don't-care while it owns the port.
    // Write takes precedence when both read and write are set.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            grant_d    <= 1'b0;
            starve_cnt <= 4'd0;
        end else if (take_d) begin
            mem_read   <= d_mem_read & ~d_mem_write;
            mem_write  <= d_mem_write;
            mem_addr   <= d_mem_addr;
            mem_wdata  <= d_mem_wdata;
            grant_d    <= 1'b1;
            if (!i_req)
                starve_cnt <= 4'd0;
            else if (starve_cnt < LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
        end else if (take_i) begin
            mem_read   <= i_mem_read & ~i_mem_write;
            mem_write  <= i_mem_write;
            mem_addr   <= i_mem_addr;
            mem_wdata  <= i_mem_wdata;
            grant_d    <= 1'b0;
            starve_cnt <= 4'd0;
        end else if (state != IDLE && mem_ready) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
        end
    end

    // Completion is steered to the owner only; a stray mem_ready in IDLE is dropped.
    assign i_mem_ready = (state == GNT_I) && mem_ready;
    assign d_mem_ready = (state == GNT_D) && mem_ready;
    assign i_mem_rdata = i_mem_ready ? mem_rdata : '0;
    assign d_mem_rdata = d_mem_ready ? mem_rdata : '0;

endmodule
